alu_core: RTL and testbench
===========================

Name: alu_core

Overview:
- Synthesizable 8-bit ALU. It is the design under test that the ALU UVM environment drives: it receives the driver's control and operand signals and produces the result and flag signals the monitor samples.
- Supports arithmetic (mode=1) and logical (mode=0) commands.
- Two-operand commands may receive their operands in separate cycles. An operand-collection FSM enforces a bounded wait for the missing operand.
- Multiply commands use a 2-stage pipeline; all other commands have 1-cycle latency.

Parameters:
- WIDTH, 8, operand width; res is 2*WIDTH bits.
- WAIT_CYCLES, 16, maximum ce-enabled cycles to wait for a missing operand.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- ce  input  1  clock enable; when 0, all state freezes.
- mode  input  1  1=arithmetic, 0=logical.
- cmd  input  4  command code.
- inp_valid  input  2  bit0=opa valid, bit1=opb valid.
- opa, opb  input  WIDTH  operands.
- cin  input  1  carry-in, used by ADD_CIN and SUB_CIN.
- res  output  2*WIDTH  result, zero-extended.
- err  output  1  illegal command, missing operand, or timeout.
- oflow  output  1  borrow/overflow.
- cout  output  1  carry out, res[WIDTH].
- g, l, e  output  1 each  CMP flags: opa>opb, opa<opb, opa==opb.

Behaviour:
- Reset: rst high at a clock edge sets all outputs to 0, state to IDLE, wait counter to 0, and flushes the multiply pipeline. Reset while in WAIT_OP or MUL drops the pending operation; no result is produced.
- Clock enable: ce=0 freezes every register (outputs, FSM, counter, pipeline).
- Arithmetic commands (mode=1):
  - 0 ADD, 1 SUB, 2 ADD_CIN, 3 SUB_CIN
  - 4 INC_A, 5 DEC_A, 6 INC_B, 7 DEC_B
  - 8 CMP
  - 9 MUL_INC = (opa+1)*(opb+1)
  - 10 MUL_SHL = (opa<<1)*opb
  - 11..15 are illegal.
- Logical commands (mode=0):
  - 0 AND, 1 NAND, 2 OR, 3 NOR, 4 XOR, 5 XNOR
  - 6 NOT_A, 7 NOT_B
  - 8 SHR1_A, 9 SHL1_A, 10 SHR1_B, 11 SHL1_B
  - 12 ROL_A_B, 13 ROR_A_B: rotate opa by opb[2:0]; opb[7:4]!=0 sets err=1.
  - 14, 15 are illegal.
  - Logical results are WIDTH bits wide with the upper bits 0.
- Operand requirements:
  - *_A and NOT_A need inp_valid[0].
  - *_B and NOT_B need inp_valid[1].
  - All other commands need both bits.
- Flags:
  - cout is set only for ADD, ADD_CIN, INC_*.
  - oflow = borrow, set only for SUB, SUB_CIN, DEC_*.
  - g/l/e are set only for CMP; CMP forces res=0.
  - Every unused flag is 0 on each new result.
  - err=1 forces res=0 and all other flags 0.
- FSM states: IDLE, WAIT_OP, MUL.
- IDLE, with ce=1:
  - inp_valid=00: no operation; outputs hold.
  - Illegal cmd: err=1 at the next edge.
  - Single-operand cmd with the wrong valid bit: err=1 at the next edge.
  - Required operands present, non-multiply: result registered at the next edge (latency 1).
  - Required operands present, multiply: go to MUL; result appears 2 edges after acceptance (latency 2), and outputs hold during the intermediate cycle.
  - Two-operand cmd with only one valid bit: latch mode, cmd, cin and the present operand; counter=0; go to WAIT_OP.
- WAIT_OP, with ce=1:
  - cmd, mode and inp bits changed while waiting are ignored.
  - The missing operand's valid bit set: latch the operand and compute, with the same latency as from IDLE.
  - Otherwise the counter increments. If the counter reaches WAIT_CYCLES with no operand: err=1, go to IDLE.
  - Consequence: with no second operand, err is visible at the 17th edge after the first operand was accepted.
- MUL: new inputs are not accepted; at the next edge the result is written and the state returns to IDLE.
- Back-to-back operation: non-multiply commands are accepted every cycle.
- Outputs hold their last value until the next result or reset.

Optional Feature:
- Macro ALU_SIGNED_EN.
- Defined: mode=1 cmd 11 SADD and cmd 12 SSUB are legal two's-complement operations. res is the sign-extended result; oflow = signed overflow; cout=0.
- Undefined: cmd 11 and 12 are illegal, err=1.

Decomposition:
- Package alu_pkg holds:
  - arith_cmd_e and logic_cmd_e enums;
  - state_e (IDLE, WAIT_OP, MUL);
  - localparams for the default width and wait count;
  - a function returning each command's required inp_valid mask.
- Sub-module alu_operand_collector holds the IDLE/WAIT_OP FSM, the operand latches and the wait counter. It presents a single "operands ready" pulse plus the latched operands and command to the datapath.

Test Plan:
- mode=1 cmd=0 opa=8'hFF opb=8'h01 inp_valid=11 -> next cycle res=16'h0100, cout=1, err=0.
- mode=1 cmd=9 opa=3 opb=4 -> res=16'h0014 exactly 2 cycles later; res unchanged 1 cycle later.
- mode=1 cmd=8 opa=5 opb=9 -> l=1, g=0, e=0, res=0; then opa=9 opb=9 -> e=1.
- mode=1 cmd=0 inp_valid=01 opa=2, 5 idle cycles, then inp_valid=10 opb=3 -> res=5, err=0. Repeat without opb -> err=1 on the 17th edge.
- mode=0 cmd=12 opa=8'h81 opb=1 -> res=16'h0003. With opb=8'h11 -> err=1, res=0.
- Issue cmd=10 then assert rst the next cycle -> all outputs 0 and no late multiply result. Also, ce=0 for 3 cycles mid-WAIT_OP -> the timeout is extended by 3 cycles.

Source files
------------

// File: rtl/alu_pkg.sv
// alu_pkg: command enums, FSM states, default sizes and decode helpers.
// Build option: ALU_SIGNED_EN makes arithmetic cmd 11/12 (SADD/SSUB) legal.
package alu_pkg;

   localparam int ALU_WIDTH       = 8;
   localparam int ALU_WAIT_CYCLES = 16;

   typedef enum logic [3:0] {
      A_ADD     = 4'd0,
      A_SUB     = 4'd1,
      A_ADD_CIN = 4'd2,
      A_SUB_CIN = 4'd3,
      A_INC_A   = 4'd4,
      A_DEC_A   = 4'd5,
      A_INC_B   = 4'd6,
      A_DEC_B   = 4'd7,
      A_CMP     = 4'd8,
      A_MUL_INC = 4'd9,
      A_MUL_SHL = 4'd10,
      A_SADD    = 4'd11,
      A_SSUB    = 4'd12
   } arith_cmd_e;

   typedef enum logic [3:0] {
      L_AND     = 4'd0,
      L_NAND    = 4'd1,
      L_OR      = 4'd2,
      L_NOR     = 4'd3,
      L_XOR     = 4'd4,
      L_XNOR    = 4'd5,
      L_NOT_A   = 4'd6,
      L_NOT_B   = 4'd7,
      L_SHR1_A  = 4'd8,
      L_SHL1_A  = 4'd9,
      L_SHR1_B  = 4'd10,
      L_SHL1_B  = 4'd11,
      L_ROL_A_B = 4'd12,
      L_ROR_A_B = 4'd13
   } logic_cmd_e;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      WAIT_OP = 2'd1,
      MUL     = 2'd2
   } state_e;

   function automatic logic cmd_legal(logic mode, logic [3:0] cmd);
      logic ok;
      if (mode) begin
`ifdef ALU_SIGNED_EN
         ok = (cmd <= A_SSUB);
`else
         ok = (cmd <= A_MUL_SHL);
`endif
      end else begin
         ok = (cmd <= L_ROR_A_B);
      end
      return ok;
   endfunction

   // bit0 = opa needed, bit1 = opb needed
   function automatic logic [1:0] req_mask(logic mode, logic [3:0] cmd);
      logic [1:0] m;
      m = 2'b11;
      if (mode) begin
         case (arith_cmd_e'(cmd))
            A_INC_A, A_DEC_A: m = 2'b01;
            A_INC_B, A_DEC_B: m = 2'b10;
            default:          m = 2'b11;
         endcase
      end else begin
         case (logic_cmd_e'(cmd))
            L_NOT_A, L_SHR1_A, L_SHL1_A: m = 2'b01;
            L_NOT_B, L_SHR1_B, L_SHL1_B: m = 2'b10;
            default:                     m = 2'b11;
         endcase
      end
      return m;
   endfunction

   function automatic logic is_mul(logic mode, logic [3:0] cmd);
      return mode && (cmd == A_MUL_INC || cmd == A_MUL_SHL);
   endfunction

endpackage

// File: rtl/alu_operand_collector.sv
// alu_operand_collector: IDLE/WAIT_OP/MUL sequencing, operand latches and
// bounded wait counter; emits a one-cycle ready or error and the operand set.
module alu_operand_collector
   import alu_pkg::*;
#(
   parameter int WIDTH       = ALU_WIDTH,
   parameter int WAIT_CYCLES = ALU_WAIT_CYCLES
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             ce,
   input  logic             mode,
   input  logic [3:0]       cmd,
   input  logic [1:0]       inp_valid,
   input  logic [WIDTH-1:0] opa,
   input  logic [WIDTH-1:0] opb,
   input  logic             cin,
   output logic             rdy,
   output logic             cerr,
   output logic             x_mode,
   output logic [3:0]       x_cmd,
   output logic             x_cin,
   output logic [WIDTH-1:0] x_opa,
   output logic [WIDTH-1:0] x_opb
);

   localparam int CW = $clog2(WAIT_CYCLES + 1);

   state_e           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             mode_q, mode_d;
   logic [3:0]       cmd_q, cmd_d;
   logic             cin_q, cin_d;
   logic [WIDTH-1:0] opa_q, opa_d;
   logic [WIDTH-1:0] opb_q, opb_d;
   logic [1:0]       have_q, have_d;
   logic [1:0]       mask;

   // Next-state, operand latching and ready/error decode
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      mode_d  = mode_q;
      cmd_d   = cmd_q;
      cin_d   = cin_q;
      opa_d   = opa_q;
      opb_d   = opb_q;
      have_d  = have_q;
      rdy     = 1'b0;
      cerr    = 1'b0;
      x_mode  = mode;
      x_cmd   = cmd;
      x_cin   = cin;
      x_opa   = opa;
      x_opb   = opb;
      mask    = req_mask(mode, cmd);
      case (state_q)
         IDLE: begin
            if (inp_valid != 2'b00) begin
               if (!cmd_legal(mode, cmd)) begin
                  cerr = 1'b1;
               end else if ((inp_valid & mask) == mask) begin
                  rdy = 1'b1;
                  if (is_mul(mode, cmd)) state_d = MUL;
               end else if (mask == 2'b11) begin
                  state_d = WAIT_OP;
                  cnt_d   = '0;
                  mode_d  = mode;
                  cmd_d   = cmd;
                  cin_d   = cin;
                  opa_d   = opa;
                  opb_d   = opb;
                  have_d  = inp_valid;
               end else begin
                  cerr = 1'b1;
               end
            end
         end
         WAIT_OP: begin
            x_mode = mode_q;
            x_cmd  = cmd_q;
            x_cin  = cin_q;
            x_opa  = have_q[0] ? opa_q : opa;
            x_opb  = have_q[1] ? opb_q : opb;
            if ((inp_valid & ~have_q) != 2'b00) begin
               rdy     = 1'b1;
               state_d = is_mul(mode_q, cmd_q) ? MUL : IDLE;
            end else if (cnt_q == CW'(WAIT_CYCLES)) begin
               cerr    = 1'b1;
               state_d = IDLE;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         MUL:     state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // State and latch registers, frozen while ce is low
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         mode_q  <= 1'b0;
         cmd_q   <= '0;
         cin_q   <= 1'b0;
         opa_q   <= '0;
         opb_q   <= '0;
         have_q  <= '0;
      end else if (ce) begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         mode_q  <= mode_d;
         cmd_q   <= cmd_d;
         cin_q   <= cin_d;
         opa_q   <= opa_d;
         opb_q   <= opb_d;
         have_q  <= have_d;
      end
   end

endmodule

// File: rtl/alu_core.sv
// alu_core: 8-bit arithmetic/logical ALU, 1-cycle ops, 2-stage multiply.
// Build option: ALU_SIGNED_EN adds signed SADD/SSUB on arithmetic cmd 11/12.
module alu_core
   import alu_pkg::*;
#(
   parameter int WIDTH       = ALU_WIDTH,
   parameter int WAIT_CYCLES = ALU_WAIT_CYCLES
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               ce,
   input  logic               mode,
   input  logic [3:0]         cmd,
   input  logic [1:0]         inp_valid,
   input  logic [WIDTH-1:0]   opa,
   input  logic [WIDTH-1:0]   opb,
   input  logic               cin,
   output logic [2*WIDTH-1:0] res,
   output logic               err,
   output logic               oflow,
   output logic               cout,
   output logic               g,
   output logic               l,
   output logic               e
);

   localparam int RW = 2 * WIDTH;
   localparam int SW = $clog2(WIDTH);
   localparam logic [WIDTH:0] ONE = {{WIDTH{1'b0}}, 1'b1};

   logic             c_rdy, c_err, c_mode, c_cin;
   logic [3:0]       c_cmd;
   logic [WIDTH-1:0] c_a, c_b;

   logic [RW-1:0]    res_q, res_d, n_res, mul_p;
   logic             err_q, err_d, n_err;
   logic             oflow_q, oflow_d, n_of;
   logic             cout_q, cout_d, n_co;
   logic             g_q, g_d, n_g;
   logic             l_q, l_d, n_l;
   logic             e_q, e_d, n_e;
   logic             mul_v_q, mul_v_d;
   logic [WIDTH:0]   mul_a_q, mul_a_d, mul_b_q, mul_b_d;

   logic [WIDTH:0]   ax, bx, ci, sum;
   logic [WIDTH-1:0] lr;
   logic [RW-1:0]    rot;
   logic [SW-1:0]    sh;

   alu_operand_collector #(
      .WIDTH       (WIDTH),
      .WAIT_CYCLES (WAIT_CYCLES)
   ) u_coll (
      .clk       (clk),
      .rst       (rst),
      .ce        (ce),
      .mode      (mode),
      .cmd       (cmd),
      .inp_valid (inp_valid),
      .opa       (opa),
      .opb       (opb),
      .cin       (cin),
      .rdy       (c_rdy),
      .cerr      (c_err),
      .x_mode    (c_mode),
      .x_cmd     (c_cmd),
      .x_cin     (c_cin),
      .x_opa     (c_a),
      .x_opb     (c_b)
   );

   // Single-cycle result and flags for the collected command
   always_comb begin
      ax    = {1'b0, c_a};
      bx    = {1'b0, c_b};
      ci    = {{WIDTH{1'b0}}, c_cin};
      sh    = c_b[SW-1:0];
      sum   = '0;
      lr    = '0;
      rot   = '0;
      n_res = '0;
      n_err = 1'b0;
      n_of  = 1'b0;
      n_co  = 1'b0;
      n_g   = 1'b0;
      n_l   = 1'b0;
      n_e   = 1'b0;
      if (c_mode) begin
         case (arith_cmd_e'(c_cmd))
            A_ADD:     begin sum = ax + bx;      n_co = sum[WIDTH]; end
            A_SUB:     begin sum = ax - bx;      n_of = sum[WIDTH]; end
            A_ADD_CIN: begin sum = ax + bx + ci; n_co = sum[WIDTH]; end
            A_SUB_CIN: begin sum = ax - bx - ci; n_of = sum[WIDTH]; end
            A_INC_A:   begin sum = ax + ONE;     n_co = sum[WIDTH]; end
            A_DEC_A:   begin sum = ax - ONE;     n_of = sum[WIDTH]; end
            A_INC_B:   begin sum = bx + ONE;     n_co = sum[WIDTH]; end
            A_DEC_B:   begin sum = bx - ONE;     n_of = sum[WIDTH]; end
            A_CMP: begin
               n_g = (c_a > c_b);
               n_l = (c_a < c_b);
               n_e = (c_a == c_b);
            end
            A_MUL_INC, A_MUL_SHL: sum = '0;
`ifdef ALU_SIGNED_EN
            A_SADD: begin
               sum  = {c_a[WIDTH-1], c_a} + {c_b[WIDTH-1], c_b};
               n_of = sum[WIDTH] ^ sum[WIDTH-1];
            end
            A_SSUB: begin
               sum  = {c_a[WIDTH-1], c_a} - {c_b[WIDTH-1], c_b};
               n_of = sum[WIDTH] ^ sum[WIDTH-1];
            end
`endif
            default: n_err = 1'b1;
         endcase
         n_res = {{(WIDTH-1){1'b0}}, sum};
`ifdef ALU_SIGNED_EN
         if (c_cmd == A_SADD || c_cmd == A_SSUB)
            n_res = {{(WIDTH-1){sum[WIDTH]}}, sum};
`endif
      end else begin
         case (logic_cmd_e'(c_cmd))
            L_AND:    lr = c_a & c_b;
            L_NAND:   lr = ~(c_a & c_b);
            L_OR:     lr = c_a | c_b;
            L_NOR:    lr = ~(c_a | c_b);
            L_XOR:    lr = c_a ^ c_b;
            L_XNOR:   lr = ~(c_a ^ c_b);
            L_NOT_A:  lr = ~c_a;
            L_NOT_B:  lr = ~c_b;
            L_SHR1_A: lr = c_a >> 1;
            L_SHL1_A: lr = c_a << 1;
            L_SHR1_B: lr = c_b >> 1;
            L_SHL1_B: lr = c_b << 1;
            L_ROL_A_B: begin
               rot = {c_a, c_a} << sh;
               lr  = rot[RW-1:WIDTH];
            end
            L_ROR_A_B: begin
               rot = {c_a, c_a} >> sh;
               lr  = rot[WIDTH-1:0];
            end
            default: n_err = 1'b1;
         endcase
         if ((c_cmd == L_ROL_A_B || c_cmd == L_ROR_A_B) &&
             c_b[WIDTH-1:4] != '0)
            n_err = 1'b1;
         n_res = {{WIDTH{1'b0}}, lr};
      end
      if (n_err) begin
         n_res = '0;
         n_of  = 1'b0;
         n_co  = 1'b0;
         n_g   = 1'b0;
         n_l   = 1'b0;
         n_e   = 1'b0;
      end
   end

   // Output update: multiply stage 2, error, or a fresh 1-cycle result
   always_comb begin
      res_d   = res_q;
      err_d   = err_q;
      oflow_d = oflow_q;
      cout_d  = cout_q;
      g_d     = g_q;
      l_d     = l_q;
      e_d     = e_q;
      mul_v_d = 1'b0;
      mul_a_d = mul_a_q;
      mul_b_d = mul_b_q;
      mul_p   = {{(WIDTH-1){1'b0}}, mul_a_q} *
                {{(WIDTH-1){1'b0}}, mul_b_q};
      if (mul_v_q) begin
         res_d   = mul_p;
         err_d   = 1'b0;
         oflow_d = 1'b0;
         cout_d  = 1'b0;
         g_d     = 1'b0;
         l_d     = 1'b0;
         e_d     = 1'b0;
      end else if (c_err) begin
         res_d   = '0;
         err_d   = 1'b1;
         oflow_d = 1'b0;
         cout_d  = 1'b0;
         g_d     = 1'b0;
         l_d     = 1'b0;
         e_d     = 1'b0;
      end else if (c_rdy) begin
         if (is_mul(c_mode, c_cmd)) begin
            mul_v_d = 1'b1;
            if (c_cmd == A_MUL_INC) begin
               mul_a_d = {1'b0, c_a} + ONE;
               mul_b_d = {1'b0, c_b} + ONE;
            end else begin
               mul_a_d = {c_a, 1'b0};
               mul_b_d = {1'b0, c_b};
            end
         end else begin
            res_d   = n_res;
            err_d   = n_err;
            oflow_d = n_of;
            cout_d  = n_co;
            g_d     = n_g;
            l_d     = n_l;
            e_d     = n_e;
         end
      end
   end

   // Output and multiply pipeline registers
   always_ff @(posedge clk) begin
      if (rst) begin
         res_q   <= '0;
         err_q   <= 1'b0;
         oflow_q <= 1'b0;
         cout_q  <= 1'b0;
         g_q     <= 1'b0;
         l_q     <= 1'b0;
         e_q     <= 1'b0;
         mul_v_q <= 1'b0;
         mul_a_q <= '0;
         mul_b_q <= '0;
      end else if (ce) begin
         res_q   <= res_d;
         err_q   <= err_d;
         oflow_q <= oflow_d;
         cout_q  <= cout_d;
         g_q     <= g_d;
         l_q     <= l_d;
         e_q     <= e_d;
         mul_v_q <= mul_v_d;
         mul_a_q <= mul_a_d;
         mul_b_q <= mul_b_d;
      end
   end

   assign res   = res_q;
   assign err   = err_q;
   assign oflow = oflow_q;
   assign cout  = cout_q;
   assign g     = g_q;
   assign l     = l_q;
   assign e     = e_q;

endmodule

// File: tb/tb_alu_core.sv
// tb_alu_core: directed vectors for alu_core with hand-computed results.
// Flags are compared as the vector {err, oflow, cout, g, l, e}.
module tb_alu_core;
   import alu_pkg::*;

   logic        clk = 1'b0;
   logic        rst, ce, mode, cin;
   logic [3:0]  cmd;
   logic [1:0]  inp_valid;
   logic [7:0]  opa, opb;
   logic [15:0] res;
   logic        err, oflow, cout, g, l, e;

   int n_chk = 0;
   int n_err = 0;

   alu_core dut (
      .clk       (clk),
      .rst       (rst),
      .ce        (ce),
      .mode      (mode),
      .cmd       (cmd),
      .inp_valid (inp_valid),
      .opa       (opa),
      .opb       (opb),
      .cin       (cin),
      .res       (res),
      .err       (err),
      .oflow     (oflow),
      .cout      (cout),
      .g         (g),
      .l         (l),
      .e         (e)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic logic [5:0] flags();
      return {err, oflow, cout, g, l, e};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic put(input logic m, input logic [3:0] c,
                      input logic [1:0] iv, input logic [7:0] a,
                      input logic [7:0] b, input logic ci);
      mode = m; cmd = c; inp_valid = iv;
      opa = a; opb = b; cin = ci;
   endtask

   task automatic run(input logic m, input logic [3:0] c,
                      input logic [1:0] iv, input logic [7:0] a,
                      input logic [7:0] b, input logic ci);
      put(m, c, iv, a, b, ci);
      tick();
      inp_valid = 2'b00;
   endtask

   task automatic chk(input string tag, input logic [15:0] r,
                      input logic [5:0] f);
      check({tag, "_res"}, res, r);
      check({tag, "_flg"}, flags(), f);
   endtask

   initial begin
      rst = 1'b1; ce = 1'b1;
      put(1'b0, 4'd0, 2'b00, 8'h00, 8'h00, 1'b0);
      tick(); tick();
      chk("reset", 16'h0000, 6'b000000);
      rst = 1'b0;

      run(1'b1, A_ADD, 2'b11, 8'hFF, 8'h01, 1'b0);
      chk("add", 16'h0100, 6'b001000);
      tick();
      check("add_hold", res, 16'h0100);
      run(1'b1, A_SUB, 2'b11, 8'h03, 8'h05, 1'b0);
      chk("sub", 16'h01FE, 6'b010000);
      run(1'b1, A_ADD_CIN, 2'b11, 8'h10, 8'h20, 1'b1);
      chk("addc", 16'h0031, 6'b000000);
      run(1'b1, A_SUB_CIN, 2'b11, 8'h10, 8'h05, 1'b1);
      chk("subc", 16'h000A, 6'b000000);
      run(1'b1, A_INC_B, 2'b10, 8'h00, 8'hFF, 1'b0);
      chk("incb", 16'h0100, 6'b001000);
      run(1'b1, A_DEC_A, 2'b01, 8'h00, 8'h00, 1'b0);
      chk("deca", 16'h01FF, 6'b010000);
      run(1'b1, A_INC_A, 2'b10, 8'h05, 8'h05, 1'b0);
      chk("inca_miss", 16'h0000, 6'b100000);

      run(1'b1, A_ADD, 2'b11, 8'h01, 8'h01, 1'b0);
      put(1'b1, A_MUL_INC, 2'b11, 8'h03, 8'h04, 1'b0);
      tick();
      inp_valid = 2'b00;
      check("mulinc_hold", res, 16'h0002);
      tick();
      chk("mulinc", 16'h0014, 6'b000000);
      put(1'b1, A_MUL_SHL, 2'b11, 8'h80, 8'h03, 1'b0);
      tick();
      inp_valid = 2'b00;
      check("mulshl_hold", res, 16'h0014);
      tick();
      chk("mulshl", 16'h0300, 6'b000000);

      run(1'b1, A_CMP, 2'b11, 8'h05, 8'h09, 1'b0);
      chk("cmp_lt", 16'h0000, 6'b000010);
      run(1'b1, A_CMP, 2'b11, 8'h09, 8'h09, 1'b0);
      chk("cmp_eq", 16'h0000, 6'b000001);
      run(1'b1, A_CMP, 2'b11, 8'h09, 8'h05, 1'b0);
      chk("cmp_gt", 16'h0000, 6'b000100);

      run(1'b0, L_AND, 2'b11, 8'hF0, 8'h3C, 1'b0);
      chk("and", 16'h0030, 6'b000000);
      run(1'b0, L_NAND, 2'b11, 8'hF0, 8'h3C, 1'b0);
      check("nand", res, 16'h00CF);
      run(1'b0, L_NOR, 2'b11, 8'hF0, 8'h0C, 1'b0);
      check("nor", res, 16'h0003);
      run(1'b0, L_XNOR, 2'b11, 8'hF0, 8'h3C, 1'b0);
      check("xnor", res, 16'h0033);
      run(1'b0, L_NOT_B, 2'b10, 8'h00, 8'h5A, 1'b0);
      check("notb", res, 16'h00A5);
      run(1'b0, L_SHL1_A, 2'b01, 8'h81, 8'h00, 1'b0);
      check("shl1a", res, 16'h0002);
      run(1'b0, L_SHR1_B, 2'b10, 8'h00, 8'h81, 1'b0);
      check("shr1b", res, 16'h0040);
      run(1'b0, L_ROL_A_B, 2'b11, 8'h81, 8'h01, 1'b0);
      chk("rol", 16'h0003, 6'b000000);
      run(1'b0, L_ROL_A_B, 2'b11, 8'h81, 8'h11, 1'b0);
      chk("rol_bad", 16'h0000, 6'b100000);
      run(1'b0, L_ROR_A_B, 2'b11, 8'h81, 8'h01, 1'b0);
      chk("ror", 16'h00C0, 6'b000000);

      run(1'b1, 4'd13, 2'b11, 8'h01, 8'h01, 1'b0);
      chk("ill_a13", 16'h0000, 6'b100000);
      run(1'b1, A_ADD, 2'b11, 8'h01, 8'h01, 1'b0);
      run(1'b0, 4'd14, 2'b11, 8'h01, 8'h01, 1'b0);
      chk("ill_l14", 16'h0000, 6'b100000);
      run(1'b1, 4'd11, 2'b11, 8'h7F, 8'h01, 1'b0);
`ifdef ALU_SIGNED_EN
      chk("sadd", 16'h0080, 6'b010000);
`else
      chk("a11_ill", 16'h0000, 6'b100000);
`endif

      run(1'b1, A_ADD, 2'b11, 8'h01, 8'h01, 1'b0);
      put(1'b1, A_ADD, 2'b01, 8'h02, 8'h00, 1'b0);
      tick();
      check("wait_hold", res, 16'h0002);
      put(1'b0, 4'hF, 2'b00, 8'h00, 8'h00, 1'b0);
      repeat (5) tick();
      put(1'b0, 4'hF, 2'b10, 8'h77, 8'h03, 1'b0);
      tick();
      inp_valid = 2'b00;
      chk("wait_add", 16'h0005, 6'b000000);

      put(1'b1, A_SUB, 2'b10, 8'h00, 8'h04, 1'b0);
      tick();
      put(1'b1, A_SUB, 2'b01, 8'h0A, 8'hEE, 1'b0);
      tick();
      inp_valid = 2'b00;
      chk("wait_bfirst", 16'h0006, 6'b000000);

      put(1'b1, A_ADD, 2'b01, 8'h02, 8'h00, 1'b0);
      tick();
      inp_valid = 2'b00;
      repeat (16) tick();
      check("to_pre", flags(), 6'b000000);
      tick();
      chk("to_err", 16'h0000, 6'b100000);

      run(1'b1, A_ADD, 2'b11, 8'h01, 8'h01, 1'b0);
      put(1'b1, A_ADD, 2'b01, 8'h02, 8'h00, 1'b0);
      tick();
      inp_valid = 2'b00;
      repeat (5) tick();
      ce = 1'b0;
      inp_valid = 2'b10;
      opb = 8'h03;
      repeat (3) tick();
      check("ce_frozen", res, 16'h0002);
      inp_valid = 2'b00;
      ce = 1'b1;
      repeat (11) tick();
      check("ce_to_pre", flags(), 6'b000000);
      tick();
      check("ce_to_err", flags(), 6'b100000);

      run(1'b1, A_ADD, 2'b11, 8'h01, 8'h01, 1'b0);
      ce = 1'b0;
      run(1'b1, A_ADD, 2'b11, 8'h40, 8'h40, 1'b0);
      check("ce_hold", res, 16'h0002);
      ce = 1'b1;

      put(1'b1, A_ADD, 2'b11, 8'h01, 8'h02, 1'b0);
      tick();
      check("b2b_1", res, 16'h0003);
      put(1'b1, A_SUB, 2'b11, 8'h09, 8'h04, 1'b0);
      tick();
      inp_valid = 2'b00;
      check("b2b_2", res, 16'h0005);

      put(1'b1, A_MUL_SHL, 2'b11, 8'h10, 8'h02, 1'b0);
      tick();
      inp_valid = 2'b00;
      rst = 1'b1;
      tick();
      chk("rst_mul", 16'h0000, 6'b000000);
      rst = 1'b0;
      tick(); tick();
      check("no_late_mul", res, 16'h0000);
      run(1'b1, A_ADD, 2'b11, 8'h20, 8'h01, 1'b0);
      check("post_rst", res, 16'h0021);

      put(1'b1, A_ADD, 2'b01, 8'h05, 8'h00, 1'b0);
      tick();
      inp_valid = 2'b00;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      put(1'b1, A_ADD, 2'b10, 8'h00, 8'h03, 1'b0);
      tick();
      inp_valid = 2'b00;
      check("rst_wait_drop", res, 16'h0000);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
